// File: rtl/multiplier_pkg.sv
// Shared types and constants for the block-decomposed multiplier.
// Retire bundle travels alongside each partial product through the multiplier.
package multiplier_pkg;

    localparam int NUM_BLOCKS  = 4;
    localparam int NUM_MULS    = NUM_BLOCKS * NUM_BLOCKS;
    localparam int MUL_LATENCY = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_FINISH  = 2'd2
    } state_t;

    typedef logic [$clog2(NUM_MULS+1)-1:0]     counter_t;
    typedef logic [$clog2(NUM_BLOCKS)-1:0]     sel_t;
    typedef logic [$clog2(2*NUM_BLOCKS-1)-1:0] shift_t;

    typedef struct packed {
        logic   valid;
        shift_t shift;
        logic   last;
    } retire_t;

    function automatic shift_t block_shift(sel_t a, sel_t b);
        return shift_t'(a) + shift_t'(b);
    endfunction

endpackage

// File: rtl/mul_schedule_ctrl_if.sv
// Handshake and datapath-control bundle of the multiplier scheduler.
// Master drives start/abort, slave (the controller) drives everything else.
interface mul_schedule_ctrl_if #(
    parameter int NUM_BLOCKS = multiplier_pkg::NUM_BLOCKS
);
    localparam int NUM_MULS = NUM_BLOCKS * NUM_BLOCKS;
    localparam int SEL_W    = $clog2(NUM_BLOCKS);
    localparam int SHIFT_W  = $clog2(2*NUM_BLOCKS-1);
    localparam int CNT_W    = $clog2(NUM_MULS+1);

    logic               start_i;
    logic               abort_i;
    logic               busy_o;
    logic               done_o;
    logic               issue_valid_o;
    logic [SEL_W-1:0]   a_sel_o;
    logic [SEL_W-1:0]   b_sel_o;
    logic               acc_clear_o;
    logic               retire_valid_o;
    logic [SHIFT_W-1:0] retire_shift_o;
    logic               retire_last_o;
    logic [CNT_W-1:0]   prod_cnt_o;

    modport master (
        output start_i, abort_i,
        input  busy_o, done_o, issue_valid_o, a_sel_o, b_sel_o,
        input  acc_clear_o, retire_valid_o, retire_shift_o,
        input  retire_last_o, prod_cnt_o
    );

    modport slave (
        input  start_i, abort_i,
        output busy_o, done_o, issue_valid_o, a_sel_o, b_sel_o,
        output acc_clear_o, retire_valid_o, retire_shift_o,
        output retire_last_o, prod_cnt_o
    );

endinterface

// File: rtl/mul_retire_delay.sv
// Delay line matching the block multiplier latency for retire tags.
// A flush empties every stage in one edge (abort and reset).
module mul_retire_delay
    import multiplier_pkg::*;
#(
    parameter int DEPTH = MUL_LATENCY
) (
    input  logic    i_clk,
    input  logic    i_flush,
    input  retire_t i_d,
    output retire_t o_q
);

    retire_t r_pipe [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_flush) begin
            for (int s = 0; s < DEPTH; s++) begin
                r_pipe[s] <= '0;
            end
        end else begin
            r_pipe[0] <= i_d;
            for (int s = 1; s < DEPTH; s++) begin
                r_pipe[s] <= r_pipe[s-1];
            end
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/mul_schedule_ctrl.sv
// Walks all (i,j) operand block pairs, one partial product per cycle,
// and tells the accumulator when and where each product lands.
module mul_schedule_ctrl
    import multiplier_pkg::*;
#(
    parameter int NUM_BLOCKS  = multiplier_pkg::NUM_BLOCKS,
    parameter int MUL_LATENCY = multiplier_pkg::MUL_LATENCY
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    mul_schedule_ctrl_if.slave ctrl
);

    localparam int N_MULS = NUM_BLOCKS * NUM_BLOCKS;
    localparam int K_W    = $clog2(N_MULS);
    localparam int SEL_W  = $clog2(NUM_BLOCKS);
    localparam int CNT_W  = $clog2(N_MULS+1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [K_W-1:0]   r_k;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    logic    w_accept;
    logic    w_issue;
    logic    w_k_last;
    logic    w_flush;
    logic    w_done_nxt;
    sel_t    w_a;
    sel_t    w_b;
    retire_t w_ret_in;
    retire_t w_ret_tail;

    assign w_accept = (r_state == ST_IDLE) & ctrl.start_i & ~ctrl.abort_i;
    assign w_issue  = (r_state == ST_COMPUTE);
    assign w_k_last = (r_k == K_W'(N_MULS-1));
    assign w_flush  = ~rst_ni | ctrl.abort_i;

    // i is the outer index, j the inner one
    assign w_a = w_issue ? r_k[K_W-1 -: SEL_W] : '0;
    assign w_b = w_issue ? r_k[SEL_W-1:0]      : '0;

    always_comb begin
        w_ret_in = '0;
        if (w_issue) begin
            w_ret_in.valid = 1'b1;
            w_ret_in.shift = block_shift(w_a, w_b);
            w_ret_in.last  = w_k_last;
        end
    end

    mul_retire_delay #(
        .DEPTH (MUL_LATENCY)
    ) u_delay (
        .i_clk   (clk_i),
        .i_flush (w_flush),
        .i_d     (w_ret_in),
        .o_q     (w_ret_tail)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:    if (w_accept) w_state_nxt = ST_COMPUTE;
            ST_COMPUTE: if (w_k_last) w_state_nxt = ST_FINISH;
            ST_FINISH:  if (r_done)   w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
        if (ctrl.abort_i) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        w_done_nxt = 1'b0;
        if (r_state != ST_IDLE && !ctrl.abort_i) begin
            w_done_nxt = w_ret_tail.valid & w_ret_tail.last;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (w_accept) begin
                r_k <= '0;
            end else if (w_issue && !w_k_last) begin
                r_k <= r_k + 1'b1;
            end
            // an abort freezes the count at what had retired so far
            if (w_accept) begin
                r_cnt <= '0;
            end else if (w_ret_tail.valid && !ctrl.abort_i) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign ctrl.busy_o         = (r_state != ST_IDLE);
    assign ctrl.done_o         = r_done;
    assign ctrl.issue_valid_o  = w_issue;
    assign ctrl.a_sel_o        = w_a;
    assign ctrl.b_sel_o        = w_b;
    assign ctrl.acc_clear_o    = w_issue & (r_k == '0);
    assign ctrl.retire_valid_o = w_ret_tail.valid;
    assign ctrl.retire_shift_o = w_ret_tail.shift;
    assign ctrl.retire_last_o  = w_ret_tail.last;
    assign ctrl.prod_cnt_o     = r_cnt;

endmodule

// File: tb/tb_mul_schedule_ctrl.sv
// Three schedulers (latency 3, 1, 8) share one stimulus stream and are
// compared every cycle against a cycle-offset model of one operation.
module tb_mul_schedule_ctrl;

    localparam int NB = 4;
    localparam int N  = NB * NB;

    logic clk = 1'b0;
    logic rst_n;
    logic st;
    logic ab;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lat
        localparam int L = (g == 0) ? 3 : ((g == 1) ? 1 : 8);

        mul_schedule_ctrl_if #(.NUM_BLOCKS(NB)) u_if ();

        assign u_if.start_i = st;
        assign u_if.abort_i = ab;

        mul_schedule_ctrl #(
            .NUM_BLOCKS  (NB),
            .MUL_LATENCY (L)
        ) u_dut (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .ctrl   (u_if)
        );

        // m_c = cycles since the edge that accepted start
        bit m_busy = 1'b0;
        int m_c    = 0;
        int m_cnt  = 0;

        function automatic int retired(int c);
            int r;
            r = c - 1 - L;
            if (r < 0) r = 0;
            if (r > N) r = N;
            return r;
        endfunction

        always @(posedge clk) begin
            if (!rst_n) begin
                m_busy <= 1'b0;
                m_cnt  <= 0;
            end else if (m_busy) begin
                if (ab) begin
                    m_busy <= 1'b0;
                    m_cnt  <= retired(m_c);
                end else if (m_c == N + L + 1) begin
                    m_busy <= 1'b0;
                    m_cnt  <= N;
                end else begin
                    m_c <= m_c + 1;
                end
            end else if (st && !ab) begin
                m_busy <= 1'b1;
                m_c    <= 1;
            end
        end

        always @(negedge clk) begin
            int k;
            int r;
            bit iv;
            bit rv;
            k  = m_c - 1;
            r  = m_c - 1 - L;
            iv = m_busy && (m_c <= N);
            rv = m_busy && (r >= 0) && (r < N);
            chk($sformatf("L%0d_busy", L), 32'(u_if.busy_o), 32'(m_busy));
            chk($sformatf("L%0d_done", L), 32'(u_if.done_o),
                32'(m_busy && m_c == N + L + 1));
            chk($sformatf("L%0d_issue", L), 32'(u_if.issue_valid_o), 32'(iv));
            chk($sformatf("L%0d_a_sel", L), 32'(u_if.a_sel_o), iv ? k / NB : 0);
            chk($sformatf("L%0d_b_sel", L), 32'(u_if.b_sel_o), iv ? k % NB : 0);
            chk($sformatf("L%0d_clr", L), 32'(u_if.acc_clear_o), 32'(iv && k == 0));
            chk($sformatf("L%0d_rvalid", L), 32'(u_if.retire_valid_o), 32'(rv));
            chk($sformatf("L%0d_rshift", L), 32'(u_if.retire_shift_o),
                rv ? (r / NB + r % NB) : 0);
            chk($sformatf("L%0d_rlast", L), 32'(u_if.retire_last_o),
                32'(rv && r == N - 1));
            chk($sformatf("L%0d_cnt", L), 32'(u_if.prod_cnt_o),
                m_busy ? retired(m_c) : m_cnt);
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        st    = 1'b0;
        ab    = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);

        // single operation
        st = 1'b1; cyc(1); st = 1'b0; cyc(25);

        // start held high across several operations
        st = 1'b1; cyc(70); st = 1'b0; cyc(25);

        // abort sampled at cycle 8, then a fresh run
        st = 1'b1; cyc(1); st = 1'b0; cyc(7);
        ab = 1'b1; cyc(1); ab = 1'b0; cyc(5);
        st = 1'b1; cyc(1); st = 1'b0; cyc(30);

        // reset mid-compute, released together with start
        st = 1'b1; cyc(1); st = 1'b0; cyc(9);
        rst_n = 1'b0; cyc(2);
        rst_n = 1'b1; st = 1'b1; cyc(1); st = 1'b0; cyc(30);

        // start and abort together in idle
        st = 1'b1; ab = 1'b1; cyc(5);
        st = 1'b0; ab = 1'b0; cyc(3);

        for (int i = 0; i < 3000; i++) begin
            st    = ($urandom_range(0, 3) == 0);
            ab    = ($urandom_range(0, 40) == 0);
            rst_n = ($urandom_range(0, 200) != 0);
            cyc(1);
        end

        rst_n = 1'b1; st = 1'b0; ab = 1'b0;
        cyc(40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_schedule_ctrl.md
# mul_schedule_ctrl

Sequencing controller for the block-decomposed pipelined multiplier. On a start request it walks every (i, j) operand block pair of a DATA_LENGTH-bit multiplication, issuing one BLOCK_LENGTH×BLOCK_LENGTH partial product per cycle to the shared block multiplier. It tracks each product through the multiplier's fixed latency and tells the accumulator when and at which block offset to add it. It sits between the top-level handshake and the block multiplier/accumulator datapath.

## Interface
Parameters:
- NUM_BLOCKS, default multiplier_pkg::NUM_BLOCKS (4): operand blocks per operand; power of two, ≥2.
- MUL_LATENCY, default 3: block multiplier latency in cycles, from issue to result; legal range 1..8.

Ports:
- clk_i  in  1  clock; all logic rising-edge.
- rst_ni  in  1  reset; synchronous, active-low.
- start_i  in  1  start request; sampled only in idle.
- abort_i  in  1  cancel the current operation.
- busy_o  out  1  high whenever state ≠ idle.
- done_o  out  1  one-cycle pulse when all NUM_MULS products have retired.
- issue_valid_o  out  1  partial product issued to the multiplier this cycle.
- a_sel_o  out  SEL_W=$clog2(NUM_BLOCKS)  operand-A block index i.
- b_sel_o  out  SEL_W  operand-B block index j.
- acc_clear_o  out  1  accumulator clear; high in the first issue cycle only.
- retire_valid_o  out  1  multiplier result valid this cycle.
- retire_shift_o  out  SHIFT_W=$clog2(2*NUM_BLOCKS-1)  block offset i+j of the retiring product.
- retire_last_o  out  1  the retiring product is the final one.
- prod_cnt_o  out  counter_t  products retired since the last start.

## Operation
- State machine uses multiplier_pkg::state_t:
  - idle → compute on start_i=1 with abort_i=0.
  - compute → finish after issue index k = NUM_MULS−1.
  - finish → idle in the done cycle.
  - Any state → idle on abort_i=1.
- compute: issue index k runs 0..NUM_MULS−1, one per cycle, with no gaps. a_sel_o = k / NUM_BLOCKS and b_sel_o = k mod NUM_BLOCKS (i outer, j inner).
- Retire pipeline: a MUL_LATENCY-deep delay line carries {valid, shift = a_sel+b_sel, last = (k = NUM_MULS−1)}. retire_* outputs come from the delay-line tail.
- prod_cnt_o clears on entry to compute and increments by 1 on each retire_valid_o. It reads NUM_MULS at done.
- finish: waits for retire_last_o, then asserts done_o for one cycle, and returns to idle on the next edge.
- start_i while busy_o=1 is ignored: no restart, no queueing.
- abort_i while busy:
  - Next cycle: state idle, delay line flushed (all retire_valid_o low), no done_o.
  - prod_cnt_o holds its value.
- abort_i and start_i together in idle: abort wins, block stays idle.
- Reset, including mid-operation: next cycle state = idle and every output = 0, with the delay line and prod_cnt_o cleared.
- Outputs are registered or decoded from registered state only; no combinational path from any input to any output.

## Timing
- Define cycle 0 as the edge where start_i is sampled.
- Issue: issue_valid_o high in cycles 1..NUM_MULS; acc_clear_o high in cycle 1 only.
- Retire: retire_valid_o high in cycles 1+MUL_LATENCY .. NUM_MULS+MUL_LATENCY; retire_last_o high in the final one.
- done_o high in cycle NUM_MULS+MUL_LATENCY+1; busy_o falls in the cycle after done_o.
- Defaults (NUM_BLOCKS=4, MUL_LATENCY=3): issue cycles 1–16, retire cycles 4–19, done in cycle 20, busy_o high cycles 1–20.
- The earliest accepted restart is start_i sampled in cycle 21, giving a first issue in cycle 22.

## Structure
- multiplier_pkg already holds state_t, counter_t, NUM_BLOCKS and NUM_MULS.
- Add to multiplier_pkg:
  - MUL_LATENCY constant;
  - sel_t typedef, logic[$clog2(NUM_BLOCKS)-1:0];
  - shift_t typedef, logic[$clog2(2*NUM_BLOCKS-1)-1:0];
  - retire_t packed struct {valid, shift, last}.
- One sub-module, mul_retire_delay: a parameterised shift register of retire_t with synchronous flush input. It is shared by the abort and reset paths.
- The controller holds the FSM, the issue index counter and the product counter.

## Test plan
- Single op, defaults: start_i pulse at cycle 0.
  - Exactly 16 issues with (a,b) = (0,0),(0,1)…(3,3).
  - retire_shift_o sequence 0,1,2,3,1,2,3,4,…,6.
  - done_o at cycle 20 and prod_cnt_o = 16.
- Start held high continuously: exactly one operation per idle window. Back-to-back done_o pulses are 21 cycles apart, and no start is accepted while busy.
- Abort at cycle 8: busy_o and retire_valid_o are low from cycle 9, no done_o, prod_cnt_o = 4. A fresh start then completes normally with prod_cnt_o = 16.
- Reset asserted at cycle 10 mid-compute: all outputs 0 at cycle 11. Reset released with start_i=1: the operation begins cleanly.
- start_i=1 and abort_i=1 together in idle: busy_o stays 0 and issue_valid_o never rises.
- Sweep MUL_LATENCY = 1 and 8: done_o at cycle 18 and 25 respectively, and retire_last_o precedes done_o by exactly 1 cycle.
